pq_stream_ctrl: RTL
===================

// Module: pq_stream_ctrl
// PURPOSE
//  Controller on the driving side of the priQueue interface (newVal/loadIn/shiftOut/clear/top).
//  Accepts a valid/ready stream of values and pushes each into the queue with loadIn.
//  On in_last or drain_req, pops the queue with shiftOut and emits the entries in priority
//  order on a valid/ready output stream. After the drain it clears the queue and re-arms.
// PARAMETERS
//  WIDTH  8  bits per entry; matches the queue's newVal/top width
//  DEPTH  6  queue capacity in entries (2..255)
// PORTS
//  ck            in   1      clock; all logic rising-edge
//  r             in   1      reset, synchronous, active-high
//  flush         in   1      sync abort: discard contents, clear queue
//  in_valid      in   1      upstream value valid
//  in_data       in   WIDTH  upstream value
//  in_last       in   1      final value of the batch (qualified by in_valid)
//  in_ready      out  1      upstream may transfer
//  drain_req     in   1      start drain without in_last (1-cycle pulse)
//  out_valid     out  1      sorted output valid
//  out_data      out  WIDTH  sorted output value
//  out_last      out  1      final entry of the drain
//  out_ready     in   1      downstream accepts
//  pq_newVal     out  WIDTH  queue newVal
//  pq_loadIn     out  1      queue loadIn
//  pq_shiftOut   out  1      queue shiftOut
//  pq_clear      out  1      queue clear
//  pq_top        in   WIDTH  queue top (highest-priority entry; valid the cycle after an update)
//  count         out  $clog2(DEPTH+1)  current occupancy
// BEHAVIOUR
//  - State machine: CLR -> IDLE/FILL -> DRAIN -> CLR. FILL and IDLE differ only in count>0.
//  - Reset:
//    - r=1 forces state CLR and count=0.
//    - in_ready, out_valid, out_last, pq_loadIn and pq_shiftOut are all 0 while r=1.
//    - The first cycle after reset is CLR: pq_clear=1. Then IDLE.
//    - Reset mid-drain or mid-fill discards all data.
//  - CLR: pq_clear=1, all other pq_* outputs 0, in_ready=0, out_valid=0; count:=0. Next state IDLE.
//  - IDLE/FILL:
//    - in_ready = (count<DEPTH).
//    - A transfer (in_valid & in_ready) sets pq_loadIn=1 and pq_newVal=in_data in the same cycle
//      (combinational), and increments count.
//    - A transfer with in_last=1, or drain_req=1 with count>0 (or with a same-cycle transfer),
//      moves to DRAIN next cycle.
//    - drain_req with count==0 and no transfer is ignored.
//    - At count==DEPTH, in_ready=0 and the block holds until drain_req.
//  - DRAIN:
//    - in_ready=0; out_valid = (count>0); out_data = pq_top (combinational); out_last = (count==1).
//    - A handshake (out_valid & out_ready) sets pq_shiftOut=1 that cycle and decrements count.
//      The queue updates top on the same edge, so one entry per cycle is sustained.
//    - out_valid/out_data stay stable while out_ready=0.
//    - The handshake with out_last=1 moves to CLR next cycle.
//  - pq_loadIn and pq_shiftOut are never 1 in the same cycle. pq_newVal=0 when pq_loadIn=0.
//  - flush=1 (lower priority than r) in any state: no load or shift that cycle, next state CLR.
//  - count never exceeds DEPTH and never underflows.
// CONFIGURATION
//  PQ_STREAM_SORTCHK_EN defined:
//    - Adds output sort_err (1 bit, reset 0, sticky until r or flush).
//    - Set when a drain emits a value greater than the previously emitted value in the same
//      drain (unsigned compare); the comparison history resets at CLR.
//  Undefined: no sort_err port and no compare logic. All other behaviour is identical.
// TESTING  (WIDTH=8, DEPTH=6, queue model is max-first)
//  - Reset: hold r 2 cycles -> pq_clear=1 the first cycle after release, then in_ready=1,
//    count=0, out_valid=0.
//  - Load 3,9,1,7 (last on 7), out_ready=1 -> out 9,7,3,1 on 4 consecutive cycles;
//    out_last only on 1; then pq_clear pulse.
//  - Load 6 values without last -> in_ready=0 at count=6; 7th in_valid held. drain_req ->
//    6 outputs, descending.
//  - Drain of 5,2 with out_ready toggling 1,0,0,1 -> out_data holds 2 across stall;
//    exactly 2 shiftOut pulses.
//  - flush during DRAIN after 1 of 3 outputs -> CLR next cycle, count=0, out_valid=0.
//    New batch 4 (last) -> out 4.
//  - SORTCHK_EN, queue model forced to emit 2 then 8 -> sort_err=1 from the cycle after 8,
//    stays until flush.

Source files
------------

// File: rtl/pq_stream_ctrl.sv
// Drives a priority queue: loads a valid/ready input batch, then pops it in priority order
// onto a valid/ready output stream and clears the queue. Optional PQ_STREAM_SORTCHK_EN adds sort_err.
module pq_stream_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 6
) (
    input  logic                       ck,
    input  logic                       r,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_last,
    output logic                       in_ready,
    input  logic                       drain_req,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           pq_newVal,
    output logic                       pq_loadIn,
    output logic                       pq_shiftOut,
    output logic                       pq_clear,
    input  logic [WIDTH-1:0]           pq_top,
    output logic [$clog2(DEPTH+1)-1:0] count,
`ifdef PQ_STREAM_SORTCHK_EN
    output logic                       sort_err,
`endif
    output logic [1:0]                 dbg_state
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        S_CLR   = 2'd0,
        S_IDLE  = 2'd1,
        S_FILL  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            fill_st;
    logic            xfer;
    logic            pop;

    // Handshakes: a beat moves on a rising edge where valid and ready are both 1; valid never
    // waits on ready, and reset or flush force every ready/valid low so no beat is half-taken.
    always_comb begin
        fill_st     = (state_q == S_IDLE) || (state_q == S_FILL);
        in_ready    = ~r & ~flush & fill_st & (count_q < DEPTH_C);
        xfer        = in_valid & in_ready;
        out_valid   = ~r & ~flush & (state_q == S_DRAIN) & (count_q != '0);
        out_last    = out_valid & (count_q == ONE_C);
        out_data    = pq_top;
        pop         = out_valid & out_ready;
        pq_loadIn   = xfer;
        pq_newVal   = xfer ? in_data : '0;
        pq_shiftOut = pop;
        pq_clear    = (state_q == S_CLR);
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_CLR: begin
                count_d = '0;
                state_d = S_IDLE;
            end
            S_IDLE, S_FILL: begin
                if (xfer) count_d = count_q + ONE_C;
                // drain_req on an empty queue is only honoured if this cycle brings a value in
                if ((xfer && in_last) || (drain_req && ((count_q != '0) || xfer)))
                    state_d = S_DRAIN;
                else
                    state_d = (count_d != '0) ? S_FILL : S_IDLE;
            end
            S_DRAIN: begin
                if (pop) count_d = count_q - ONE_C;
                if ((pop && out_last) || (count_q == '0)) state_d = S_CLR;
            end
            default: state_d = S_CLR;
        endcase
        if (flush) begin
            state_d = S_CLR;
            count_d = '0;
        end
    end

`ifdef PQ_STREAM_SORTCHK_EN
    logic [WIDTH-1:0] prev_out_q, prev_out_d;
    logic             seen_q, seen_d;
    logic             sort_err_q, sort_err_d;

    // Each emitted value must not exceed the one emitted before it in the same drain.
    always_comb begin
        prev_out_d = prev_out_q;
        seen_d     = seen_q;
        sort_err_d = sort_err_q;
        if (state_q == S_CLR) seen_d = 1'b0;
        if (pop) begin
            if (seen_q && (pq_top > prev_out_q)) sort_err_d = 1'b1;
            prev_out_d = pq_top;
            seen_d     = 1'b1;
        end
        if (flush) begin
            sort_err_d = 1'b0;
            seen_d     = 1'b0;
        end
    end

    assign sort_err = sort_err_q;
`endif

    always_ff @(posedge ck) begin
        if (r) begin
            state_q <= S_CLR;
            count_q <= '0;
`ifdef PQ_STREAM_SORTCHK_EN
            prev_out_q <= '0;
            seen_q     <= 1'b0;
            sort_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
`ifdef PQ_STREAM_SORTCHK_EN
            prev_out_q <= prev_out_d;
            seen_q     <= seen_d;
            sort_err_q <= sort_err_d;
`endif
        end
    end

    assign count     = count_q;
    assign dbg_state = state_q;

endmodule
